axi_lite_cmd_sequencer: RTL and testbench

AXI_LITE_CMD_SEQUENCER -- requirements
Module: axi_lite_cmd_sequencer

---
 rtl/axi_lite_cmd_sequencer.sv | 173 +++++++++++++++++
 tb/tb_axi_lite_cmd_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cmd_sequencer.sv
// AXI-Lite command sequencer: buffers commands in a small FIFO and issues them
// one at a time to a downstream AXI-Lite master. Each command waits for its
// response or for a timeout before it completes. Only one command is in flight.
module axi_lite_cmd_sequencer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [WIDTH-1:0]         cmd_addr,
  input  logic [WIDTH-1:0]         cmd_wdata,
  input  logic [WIDTH/8-1:0]       cmd_wstrb,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic                     req_write,
  output logic [WIDTH-1:0]         req_addr,
  output logic [WIDTH-1:0]         req_wdata,
  output logic [WIDTH/8-1:0]       req_wstrb,
  input  logic                     rsp_valid,
  input  logic [1:0]               rsp_resp,
  input  logic [WIDTH-1:0]         rsp_rdata,
  output logic                     res_valid,
  output logic                     res_write,
  output logic [1:0]               res_resp,
  output logic [WIDTH-1:0]         res_rdata,
  output logic                     res_timeout,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = WIDTH / 8;
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO  = CW'(TIMEOUT);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  // FIFO storage and bookkeeping
  logic             mem_write_q [DEPTH];
  logic [WIDTH-1:0] mem_addr_q  [DEPTH];
  logic [WIDTH-1:0] mem_wdata_q [DEPTH];
  logic [SW-1:0]    mem_wstrb_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  // FSM and registered outputs
  state_t           state_q;
  logic [CW-1:0]    wcnt_q;
  logic             req_valid_q, req_write_q;
  logic [WIDTH-1:0] req_addr_q, req_wdata_q;
  logic [SW-1:0]    req_wstrb_q;
  logic             res_valid_q, res_write_q, res_timeout_q;
  logic [1:0]       res_resp_q;
  logic [WIDTH-1:0] res_rdata_q;

  // A full FIFO refuses a push even when a pop frees a slot this cycle.
  assign cmd_ready = (count_q != FULL);
  assign push      = cmd_valid && cmd_ready;
  // req_valid is registered high for the whole of ISSUE, so ISSUE + ready is the handshake.
  assign pop       = (state_q == S_ISSUE) && req_ready;

  // Next occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Payload storage; contents need no reset since the pointers define validity.
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_write_q[wr_ptr_q] <= cmd_write;
      mem_addr_q[wr_ptr_q]  <= cmd_addr;
      mem_wdata_q[wr_ptr_q] <= cmd_wdata;
      mem_wstrb_q[wr_ptr_q] <= cmd_wstrb;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Sequencer: load the head into req_*, hold it until accepted, then wait
  // for the response (or time out) and publish a one-cycle result.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q       <= S_IDLE;
      wcnt_q        <= '0;
      req_valid_q   <= 1'b0;
      req_write_q   <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      req_wstrb_q   <= '0;
      res_valid_q   <= 1'b0;
      res_write_q   <= 1'b0;
      res_resp_q    <= 2'b00;
      res_rdata_q   <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (count_q != '0) begin
          state_q     <= S_ISSUE;
          req_valid_q <= 1'b1;
          req_write_q <= mem_write_q[rd_ptr_q];
          req_addr_q  <= mem_addr_q[rd_ptr_q];
          req_wdata_q <= mem_wdata_q[rd_ptr_q];
          req_wstrb_q <= mem_wstrb_q[rd_ptr_q];
        end
        S_ISSUE: if (req_ready) begin
          state_q     <= S_WAIT;
          req_valid_q <= 1'b0;
          wcnt_q      <= '0;
        end
        S_WAIT: begin
          // A response arriving on the timeout cycle takes priority.
          if (rsp_valid) begin
            state_q       <= S_DONE;
            res_valid_q   <= 1'b1;
            res_write_q   <= req_write_q;
            res_resp_q    <= rsp_resp;
            res_rdata_q   <= req_write_q ? '0 : rsp_rdata;
            res_timeout_q <= 1'b0;
          end else if (wcnt_q == TMO) begin
            state_q       <= S_DONE;
            res_valid_q   <= 1'b1;
            res_write_q   <= req_write_q;
            res_resp_q    <= 2'b10;
            res_rdata_q   <= '0;
            res_timeout_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          res_valid_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_valid   = req_valid_q;
  assign req_write   = req_write_q;
  assign req_addr    = req_addr_q;
  assign req_wdata   = req_wdata_q;
  assign req_wstrb   = req_wstrb_q;
  assign res_valid   = res_valid_q;
  assign res_write   = res_write_q;
  assign res_resp    = res_resp_q;
  assign res_rdata   = res_rdata_q;
  assign res_timeout = res_timeout_q;
  assign fifo_count  = count_q;
  assign busy        = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_axi_lite_cmd_sequencer.sv
// Bench for axi_lite_cmd_sequencer: commands push expected requests/results into
// queues; a downstream responder and a result monitor pop and compare them.
module tb_axi_lite_cmd_sequencer;
  localparam int TMO = 255;

  logic        ACLK = 1'b0, ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_rdata;
  logic        res_valid, res_write, res_timeout;
  logic [1:0]  res_resp;
  logic [31:0] res_rdata;
  logic [2:0]  fifo_count;
  logic        busy;

  axi_lite_cmd_sequencer #(.WIDTH(32), .DEPTH(4), .TIMEOUT(TMO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
    .res_valid(res_valid), .res_write(res_write), .res_resp(res_resp),
    .res_rdata(res_rdata), .res_timeout(res_timeout),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic w; logic [31:0] addr, wdata; logic [3:0] strb;
    logic [1:0] resp; logic [31:0] rdata; int dly; bit respond;
  } req_t;
  typedef struct {
    logic w; logic [1:0] resp; logic [31:0] rdata; logic to; int lat;
  } res_t;

  req_t req_q[$];
  res_t exp_q[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, hs_cyc = 0;
  bit   pend = 0;
  int   cnt_w = 0;
  req_t cur;
  logic prev_rv = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(posedge ACLK) cyc <= cyc + 1;

  // Downstream model: checks each accepted request against push order and
  // answers it after its programmed delay (or never, to force a timeout).
  initial begin
    rsp_valid = 0; rsp_resp = 0; rsp_rdata = 0;
    forever begin
      @(negedge ACLK);
      rsp_valid = 0; rsp_resp = 0; rsp_rdata = 0;
      if (pend && !ARESET) begin
        if (cnt_w > 1) cnt_w--;
        else begin
          pend = 0; rsp_valid = 1; rsp_resp = cur.resp; rsp_rdata = cur.rdata;
        end
      end
      if (!ARESET && req_valid && req_ready) begin
        if (req_q.size() == 0) chk("req_unexpected", req_valid, 0);
        else begin
          cur = req_q.pop_front();
          chk("req_write", req_write, cur.w);
          chk("req_addr",  req_addr,  cur.addr);
          chk("req_wdata", req_wdata, cur.wdata);
          chk("req_wstrb", req_wstrb, cur.strb);
          pend = cur.respond; cnt_w = cur.dly; hs_cyc = cyc + 1;
        end
      end
    end
  end

  // Result monitor: one-cycle pulse, contents and latency from the handshake.
  always @(negedge ACLK) begin
    if (!ARESET && res_valid) begin
      chk("res_single_pulse", prev_rv, 0);
      if (exp_q.size() == 0) chk("res_unexpected", res_valid, 0);
      else if (!prev_rv) begin
        res_t e;
        e = exp_q.pop_front();
        chk("res_write",   res_write,   e.w);
        chk("res_resp",    res_resp,    e.resp);
        chk("res_rdata",   res_rdata,   e.rdata);
        chk("res_timeout", res_timeout, e.to);
        chk("res_latency", cyc - hs_cyc, e.lat);
      end
    end
    prev_rv = res_valid;
  end

  // Drive one command (called #1 after a rising edge); returns #1 after the push edge.
  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] rr, input logic [31:0] rd,
                          input int dly, input bit respond);
    req_t q; res_t e; int n;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 2000) begin @(posedge ACLK); #1; n++; end
    if (!cmd_ready) chk("push_timeout", cmd_ready, 1);
    else begin
      q = '{w, a, d, s, rr, rd, dly, respond};
      req_q.push_back(q);
      if (respond) e = '{w, rr, (w ? 32'h0 : rd), 1'b0, dly};
      else         e = '{w, 2'b10, 32'h0, 1'b1, TMO + 1};
      exp_q.push_back(e);
    end
    @(posedge ACLK); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin @(posedge ACLK); #1; n++; end
    chk("drain_busy", busy, 0);
    chk("drain_queue", exp_q.size(), 0);
  endtask

  initial begin
    ARESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    cmd_wstrb = 0; req_ready = 0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", res_timeout, 0);
    chk("rst_req_addr", req_addr, 0);
    ARESET = 0;
    @(posedge ACLK); #1;

    // Single write, then single read with hold check
    req_ready = 1;
    push_cmd(1, 32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0, 2, 1);
    chk("req_lat_before", req_valid, 0);
    @(posedge ACLK); #1;
    chk("req_lat_after", req_valid, 1);
    chk("req_lat_addr", req_addr, 32'h10);
    wait_done();
    push_cmd(0, 32'h10, 32'h0, 4'h0, 2'b00, 32'h000000AB, 2, 1);
    wait_done();
    repeat (3) @(posedge ACLK);
    #1;
    chk("hold_rdata", res_rdata, 32'hAB);
    chk("hold_write", res_write, 0);

    // Mixed traffic with varied responses and delays
    for (int i = 0; i < 6; i++)
      push_cmd(i[0], 32'h100 + 4 * i, $urandom, 4'(i + 3), 2'(i), $urandom, 1 + i % 3, 1);
    wait_done();

    // Full FIFO: fifth command stalls until the downstream accepts
    req_ready = 0;
    for (int i = 0; i < 4; i++)
      push_cmd(1, 32'(4 * i), 32'hA0 + i, 4'hF, 2'b00, 32'h0, 1, 1);
    chk("full_count", fifo_count, 4);
    chk("full_ready", cmd_ready, 0);
    fork
      push_cmd(0, 32'h10, 32'h0, 4'h0, 2'b01, 32'h5555AAAA, 1, 1);
      begin
        repeat (3) @(posedge ACLK);
        #1;
        chk("full_stall_count", fifo_count, 4);
        chk("full_stall_ready", cmd_ready, 0);
        chk("full_stall_addr", req_addr, 32'h0);
        req_ready = 1;
      end
    join
    wait_done();

    // Backpressure: request held stable for 7 cycles, pop only on handshake
    req_ready = 0;
    push_cmd(1, 32'h40, 32'h12345678, 4'h3, 2'b11, 32'h0, 1, 1);
    @(posedge ACLK); #1;
    for (int i = 0; i < 7; i++) begin
      chk("bp_valid", req_valid, 1);
      chk("bp_addr", req_addr, 32'h40);
      chk("bp_wdata", req_wdata, 32'h12345678);
      chk("bp_wstrb", req_wstrb, 4'h3);
      chk("bp_count", fifo_count, 1);
      @(posedge ACLK); #1;
    end
    req_ready = 1;
    @(posedge ACLK); #1;
    chk("bp_pop", fifo_count, 0);
    chk("bp_drop", req_valid, 0);
    wait_done();

    // Timeout, then a response landing on the timeout cycle
    push_cmd(0, 32'h80, 32'h0, 4'h0, 2'b00, 32'h0, 1, 0);
    wait_done();
    chk("to_flag_hold", res_timeout, 1);
    push_cmd(0, 32'h84, 32'h0, 4'h0, 2'b01, 32'hCAFEF00D, TMO + 1, 1);
    wait_done();

    // Reset mid-WAIT with two commands queued
    push_cmd(0, 32'h200, 32'h0, 4'h0, 2'b00, 32'h0, 1, 0);
    push_cmd(1, 32'h204, 32'h1, 4'hF, 2'b00, 32'h0, 1, 1);
    push_cmd(1, 32'h208, 32'h2, 4'hF, 2'b00, 32'h0, 1, 1);
    repeat (5) @(posedge ACLK);
    #1;
    chk("prerst_count", fifo_count, 2);
    chk("prerst_busy", busy, 1);
    #3 ARESET = 1;
    #1;
    chk("rst_mid_count", fifo_count, 0);
    chk("rst_mid_req_valid", req_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    exp_q.delete(); req_q.delete(); pend = 0;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 0;
    repeat (3) @(posedge ACLK);
    #1;
    push_cmd(0, 32'h300, 32'h0, 4'h0, 2'b00, 32'h77, 3, 1);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
